// File: rtl/regfile_mp.sv
// Multi-ported register file: two write ports, NUM_RD combinational read ports with write
// bypass, and a per-register pending scoreboard with an incremental pending count.
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 3,
    parameter int ZERO_R0 = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr,
    output logic [ADDR_W:0]          pend_cnt,
    output logic                     sb_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pending;

    logic w0_ok, w1_ok, w0_eff, sb_ok;
    logic clr0, clr1, set_inc;

    // Operations aimed at a hardwired-zero r0 are dropped up front so nothing below sees them.
    always_comb begin
        w0_ok   = we0 && !((ZERO_R0 != 0) && (waddr0 == '0));
        w1_ok   = we1 && !((ZERO_R0 != 0) && (waddr1 == '0));
        sb_ok   = sb_set && !((ZERO_R0 != 0) && (sb_addr == '0));
        w0_eff  = w0_ok && !(w1_ok && (waddr1 == waddr0));
        set_inc = sb_ok && !pending[sb_addr];
        clr0    = w0_eff && pending[waddr0] && !(sb_ok && (sb_addr == waddr0));
        clr1    = w1_ok && pending[waddr1] && !(sb_ok && (sb_addr == waddr1));
    end

    // NOTE: the array is reset because reads of any register must return 0 straight after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (w0_eff) mem[waddr0] <= wdata0;
            if (w1_ok)  mem[waddr1] <= wdata1;
        end
    end

    // NOTE: non-blocking updates make the last assignment win, so the set placed after the clears overrides them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            pend_cnt <= '0;
            sb_err   <= 1'b0;
        end else begin
            if (w0_ok) pending[waddr0] <= 1'b0;
            if (w1_ok) pending[waddr1] <= 1'b0;
            if (sb_ok) pending[sb_addr] <= 1'b1;
            pend_cnt <= pend_cnt + (ADDR_W+1)'(set_inc) - (ADDR_W+1)'(clr0) - (ADDR_W+1)'(clr1);
            if (sb_ok && pending[sb_addr]) sb_err <= 1'b1;
        end
    end

    // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
    always_comb begin
        logic [ADDR_W-1:0] a;
        logic              hit0, hit1;
        rdata = '0;
        rbusy = '0;
        a     = '0;
        hit0  = 1'b0;
        hit1  = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            a    = raddr[i*ADDR_W +: ADDR_W];
            hit0 = we0 && (waddr0 == a);
            hit1 = we1 && (waddr1 == a);
            if (rst || ((ZERO_R0 != 0) && (a == '0)) || !re[i]) begin
                rdata[i*DATA_W +: DATA_W] = '0;
                rbusy[i]                  = 1'b0;
            end else begin
                if (hit1)      rdata[i*DATA_W +: DATA_W] = wdata1;
                else if (hit0) rdata[i*DATA_W +: DATA_W] = wdata0;
                else           rdata[i*DATA_W +: DATA_W] = mem[a];
                rbusy[i] = pending[a] && !hit0 && !hit1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a vector table feeds a queue of expectations that is
// drained against the DUT, followed by hand-written reset sequences.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        we0, we1, sb_set;
    logic [4:0]  waddr0, waddr1, sb_addr;
    logic [31:0] wdata0, wdata1;
    logic [2:0]  re;
    logic [14:0] raddr;
    logic [95:0] rdata;
    logic [2:0]  rbusy;
    logic [5:0]  pend_cnt;
    logic        sb_err;

    int errors = 0;
    int checks = 0;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .ZERO_R0(1)) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .sb_set(sb_set), .sb_addr(sb_addr), .pend_cnt(pend_cnt), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [2:0]  re;
        logic [14:0] ra;
        logic        sb;
        logic [4:0]  sa;
        logic [95:0] x_rdata;
        logic [2:0]  x_rbusy;
        logic [5:0]  x_cnt;
        logic        x_err;
    } vec_t;

    typedef struct {
        logic [95:0] rdata;
        logic [2:0]  rbusy;
        logic [5:0]  cnt;
        logic        err;
    } exp_t;

    vec_t vecs[17];
    exp_t sb_q[$];

    function automatic logic [14:0] ra3(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        return {a2, a1, a0};
    endfunction

    function automatic logic [95:0] rd3(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        return {d2, d1, d0};
    endfunction

    function automatic vec_t mk(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                                input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                                input logic [2:0] r, input logic [14:0] ra,
                                input logic s, input logic [4:0] sa,
                                input logic [95:0] xd, input logic [2:0] xb,
                                input logic [5:0] xc, input logic xe);
        vec_t v;
        v.we0 = w0; v.wa0 = a0; v.wd0 = d0;
        v.we1 = w1; v.wa1 = a1; v.wd1 = d1;
        v.re = r; v.ra = ra; v.sb = s; v.sa = sa;
        v.x_rdata = xd; v.x_rbusy = xb; v.x_cnt = xc; v.x_err = xe;
        return v;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        we0 = 0; waddr0 = '0; wdata0 = '0;
        we1 = 0; waddr1 = '0; wdata1 = '0;
        re = '0; raddr = '0; sb_set = 0; sb_addr = '0;
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        we0 = v.we0; waddr0 = v.wa0; wdata0 = v.wd0;
        we1 = v.we1; waddr1 = v.wa1; wdata1 = v.wd1;
        re = v.re; raddr = v.ra; sb_set = v.sb; sb_addr = v.sa;
        e.rdata = v.x_rdata; e.rbusy = v.x_rbusy; e.cnt = v.x_cnt; e.err = v.x_err;
        sb_q.push_back(e);
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;

    initial begin
        exp_t e;
        vecs[0]  = mk(1, 5, DB, 0, 0, 0, 3'b001, ra3(5, 0, 0), 0, 0, rd3(DB, 0, 0), 3'b000, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 3'b111, ra3(5, 5, 5), 0, 0, rd3(DB, DB, DB), 3'b000, 0, 0);
        vecs[2]  = mk(1, 7, 32'h11, 1, 7, 32'h22, 3'b011, ra3(7, 7, 0), 0, 0, rd3(32'h22, 32'h22, 0), 3'b000, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 3'b111, ra3(7, 5, 7), 0, 0, rd3(32'h22, DB, 32'h22), 3'b000, 0, 0);
        vecs[4]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0, 3'b111, ra3(0, 0, 0), 0, 0, rd3(0, 0, 0), 3'b000, 0, 0);
        vecs[5]  = mk(0, 0, 0, 1, 0, 32'hFFFFFFFF, 3'b111, ra3(0, 5, 0), 0, 0, rd3(0, DB, 0), 3'b000, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 3'b001, ra3(3, 0, 0), 1, 3, rd3(0, 0, 0), 3'b000, 1, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 3'b001, ra3(3, 3, 0), 0, 0, rd3(0, 0, 0), 3'b001, 1, 0);
        vecs[8]  = mk(0, 0, 0, 1, 3, 32'h5, 3'b001, ra3(3, 0, 0), 0, 0, rd3(32'h5, 0, 0), 3'b000, 0, 0);
        vecs[9]  = mk(1, 4, 32'h44, 0, 0, 0, 3'b001, ra3(4, 0, 0), 1, 4, rd3(32'h44, 0, 0), 3'b000, 1, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 3'b001, ra3(4, 0, 0), 1, 4, rd3(32'h44, 0, 0), 3'b001, 1, 1);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 3'b111, ra3(0, 4, 0), 1, 0, rd3(0, 32'h44, 0), 3'b010, 1, 1);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 3'b001, ra3(4, 0, 0), 1, 1, rd3(32'h44, 0, 0), 3'b001, 2, 1);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 3'b010, ra3(0, 1, 0), 1, 2, rd3(0, 0, 0), 3'b010, 3, 1);
        vecs[14] = mk(1, 1, 32'h1111, 1, 2, 32'h2222, 3'b111, ra3(1, 2, 6), 1, 6,
                      rd3(32'h1111, 32'h2222, 0), 3'b000, 2, 1);
        vecs[15] = mk(1, 4, 32'h4444, 1, 6, 32'h6666, 3'b111, ra3(4, 6, 1), 0, 0,
                      rd3(32'h4444, 32'h6666, 32'h1111), 3'b000, 0, 1);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 3'b111, ra3(2, 4, 6), 0, 0,
                      rd3(32'h2222, 32'h4444, 32'h6666), 3'b000, 0, 1);

        // Reset held across edges with a write and an issue pending on the inputs.
        idle();
        rst = 1'b1;
        we0 = 1; waddr0 = 9; wdata0 = 32'h1234; sb_set = 1; sb_addr = 9;
        re = 3'b111; raddr = ra3(9, 9, 9);
        #2;
        check("rst_rdata", rdata, 96'h0);
        check("rst_rbusy", {93'h0, rbusy}, 96'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_cnt", {90'h0, pend_cnt}, 96'h0);
        check("rst_err", {95'h0, sb_err}, 96'h0);
        @(negedge clk);
        idle();
        rst = 1'b0;
        re = 3'b001; raddr = ra3(9, 0, 0);
        #2;
        check("rst_discard_r9", rdata, 96'h0);
        check("rst_discard_busy", {93'h0, rbusy}, 96'h0);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #2;
            e = sb_q[0];
            check($sformatf("v%0d_rdata", i), rdata, e.rdata);
            check($sformatf("v%0d_rbusy", i), {93'h0, rbusy}, {93'h0, e.rbusy});
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            check($sformatf("v%0d_cnt", i), {90'h0, pend_cnt}, {90'h0, e.cnt});
            check($sformatf("v%0d_err", i), {95'h0, sb_err}, {95'h0, e.err});
        end

        // Two registers pending, then an asynchronous reset in the middle of a write cycle.
        @(negedge clk);
        idle(); sb_set = 1; sb_addr = 1;
        @(negedge clk);
        sb_addr = 2;
        @(posedge clk);
        #1;
        check("pre_rst_cnt", {90'h0, pend_cnt}, 96'd2);
        @(negedge clk);
        idle();
        we0 = 1; waddr0 = 1; wdata0 = 32'hABCD; sb_set = 1; sb_addr = 3;
        re = 3'b111; raddr = ra3(1, 2, 5);
        #1;
        check("pre_rst_rbusy", {93'h0, rbusy}, 96'b010);
        #2;
        rst = 1'b1;
        #1;
        check("async_rdata", rdata, 96'h0);
        check("async_rbusy", {93'h0, rbusy}, 96'h0);
        check("async_cnt", {90'h0, pend_cnt}, 96'h0);
        check("async_err", {95'h0, sb_err}, 96'h0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        re = 3'b111; raddr = ra3(1, 2, 5);
        #2;
        check("post_rst_rdata", rdata, 96'h0);
        check("post_rst_rbusy", {93'h0, rbusy}, 96'h0);
        check("post_rst_cnt", {90'h0, pend_cnt}, 96'h0);

        // Normal operation resumes after reset.
        @(negedge clk);
        we0 = 1; waddr0 = 1; wdata0 = 32'h77;
        @(negedge clk);
        idle(); re = 3'b001; raddr = ra3(1, 0, 0);
        #2;
        check("post_rst_write", rdata, rd3(32'h77, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
